// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// The FSM encoding is fixed at two bits so the state register width never drifts.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_bit_cell.sv
// One-bit full-add cell with the b input inverted: a + ~b + cin.
// Chaining it LSB first with an initial carry of 1 yields a - b.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic d,
    output logic cout
);

    logic b_n;

    always_comb begin
        b_n  = ~b;
        d    = a ^ b_n ^ cin;
        cout = (a & b_n) | (a & cin) | (b_n & cin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Operands are taken only from IDLE; the result is held in DONE until out_ready.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic             cell_d;
    logic             cell_cout;

    sub_bit_cell u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (carry_q),
        .d    (cell_d),
        .cout (cell_cout)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                diff_d  = {cell_d, diff_q[WIDTH-1:1]};
                carry_d = cell_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // carry_q here is the carry into the MSB step
                    borrow_d = ~cell_cout;
                    ovf_d    = carry_q ^ cell_cout;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: hand-computed vectors,
// back-pressure, ignored mid-run operands, mid-run reset and a back-to-back sweep.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid with a bound; returns the number of edges waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    // Present one operand pair from IDLE, expect the result after WIDTH edges,
    // then handshake and confirm the return to IDLE.
    task automatic run_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check({name, ".latency"}, 32'(n), 32'(WIDTH));
        check({name, ".diff"}, 32'(diff), 32'(ed));
        check({name, ".borrow"}, 32'(borrow), 32'(eb));
        check({name, ".ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, ".idle_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int prev_t;
        logic [7:0] ea, eb8, ed;
        logic       ebr, eov;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) step();
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.diff", 32'(diff), 32'd0);
        check("rst.borrow", 32'(borrow), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();

        run_op("t100_37", 8'd100, 8'd37, 8'd63, 1'b0, 1'b0);
        run_op("t5_9", 8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
        run_op("t80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("t7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op("teq", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0);
        run_op("tb0", 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0);

        // Back-pressure: result must hold while out_ready stays low
        a        = 8'd200;
        b        = 8'd55;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check("bp.latency", 32'(n), 32'(WIDTH));
        for (int k = 0; k < 5; k++) begin
            check("bp.diff", 32'(diff), 32'd145);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready", 32'(in_ready), 32'd0);
            step();
        end
        check("bp.diff_last", 32'(diff), 32'd145);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp.idle", 32'(in_ready), 32'd1);

        // Operands pulsed mid-run are ignored, not queued
        a        = 8'd100;
        b        = 8'd37;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        a        = 8'd1;
        b        = 8'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(n);
        check("ign.latency", 32'(n + 3), 32'(WIDTH));
        check("ign.diff", 32'(diff), 32'd63);
        check("ign.borrow", 32'(borrow), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        check("ign.no_queue_ready", 32'(in_ready), 32'd1);
        check("ign.no_queue_valid", 32'(out_valid), 32'd0);
        run_op("ign.represent", 8'd1, 8'd1, 8'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-run discards the operation
        a        = 8'd200;
        b        = 8'd55;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("arst.in_ready", 32'(in_ready), 32'd1);
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.diff", 32'(diff), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_op("arst.next", 8'd10, 8'd3, 8'd7, 1'b0, 1'b0);

        // Back-to-back sweep with in_valid held high and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_t    = 0;
        for (int i = 0; i < 256; i++) begin
            ea  = 8'(i);
            eb8 = 8'(i / 2);
            a   = ea;
            b   = eb8;
            ed  = ea - eb8;
            ebr = (ea < eb8);
            eov = (ea[7] != eb8[7]) && (ed[7] != ea[7]);
            n = 0;
            while (!in_ready && n < 40) begin
                step();
                n++;
            end
            check("sweep.ready_wait", 32'(n < 40), 32'd1);
            if (i > 0) check("sweep.interval", 32'(cyc - prev_t), 32'(WIDTH + 2));
            prev_t = cyc;
            step();
            wait_valid(n);
            check("sweep.latency", 32'(n), 32'(WIDTH));
            check("sweep.diff", 32'(diff), 32'(ed));
            check("sweep.borrow", 32'(borrow), 32'(ebr));
            check("sweep.ovf", 32'(ovf), 32'(eov));
        end
        in_valid  = 1'b0;
        step();
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
